// File: rtl/emern_spi_host.sv
// SPI mode-0 initiator: framed byte stream out on mosi (MSB first), miso bytes back on rx_data.
// Optional macro SPI_HOST_TIMEOUT_EN: abort a frame whose INT wait reaches TIMEOUT_CYCLES.
module emern_spi_host #(
  parameter int CLK_DIV        = 4,
  parameter int CS_GAP         = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  input  logic       tx_sync,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       err,
  output logic       cs_n_out,
  output logic       sck_out,
  output logic       mosi_out,
  input  logic       miso_in,
  input  logic       int_in
);

  typedef enum logic [2:0] {IDLE, WAIT_INT, SETUP, SHIFT, NEXT, HOLD, GAP, DROP} state_t;

  state_t     state;
  logic [7:0] div_cnt;
  logic [7:0] tick_cnt;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       last_q;
  logic [1:0] int_sync;
  logic       timed;
  logic       tick;
  logic       take;
  logic       timeout;

  assign timed = state inside {SETUP, SHIFT, HOLD, GAP};
  assign tick  = timed && (div_cnt == 8'(CLK_DIV - 1));
  assign take  = tx_ready && tx_valid;
  assign busy  = (state != IDLE);

`ifdef SPI_HOST_TIMEOUT_EN
  logic [31:0] to_cnt;

  assign timeout = (state == WAIT_INT) && !int_sync[1] &&
                   (to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err    <= timeout;
      to_cnt <= (state == WAIT_INT && !timeout) ? to_cnt + 32'd1 : 32'd0;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // NOTE: every register here uses <= so all updates in a cycle see the pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; a mid-frame reset drops CS on the very next edge.
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      tick_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      last_q   <= 1'b0;
      int_sync <= '0;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      cs_n_out <= 1'b1;
      sck_out  <= 1'b0;
      mosi_out <= 1'b0;
    end else begin
      int_sync <= {int_sync[0], int_in};
      rx_valid <= 1'b0;
      div_cnt  <= (timed && !tick) ? div_cnt + 8'd1 : 8'd0;

      case (state)
        IDLE: begin
          if (take) begin
            tx_ready <= 1'b0;
            tx_sh    <= tx_data;
            last_q   <= tx_last;
            if (tx_sync) begin
              state <= WAIT_INT;
            end else begin
              state    <= SETUP;
              cs_n_out <= 1'b0;
              mosi_out <= tx_data[7];
            end
          end else begin
            tx_ready <= 1'b1;
          end
        end

        WAIT_INT: begin
          if (int_sync[1]) begin
            state    <= SETUP;
            cs_n_out <= 1'b0;
            mosi_out <= tx_sh[7];
          end else if (timeout) begin
            // Abandon the frame; the remaining bytes are swallowed in DROP.
            tx_ready <= 1'b1;
            state    <= last_q ? IDLE : DROP;
          end
        end

        SETUP: begin
          if (tick) begin
            state    <= SHIFT;
            tick_cnt <= '0;
          end
        end

        SHIFT: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 8'd1;
            if (!tick_cnt[0]) begin
              sck_out <= 1'b1;
              rx_sh   <= {rx_sh[6:0], miso_in};
            end else begin
              sck_out <= 1'b0;
              if (tick_cnt == 8'd15) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
                tick_cnt <= '0;
                if (last_q) begin
                  state <= HOLD;
                end else begin
                  state    <= NEXT;
                  tx_ready <= 1'b1;
                end
              end else begin
                tx_sh    <= {tx_sh[6:0], 1'b0};
                mosi_out <= tx_sh[6];
              end
            end
          end
        end

        NEXT: begin
          // No byte offered means a stall with CS low and SCK low.
          if (take) begin
            tx_ready <= 1'b0;
            tx_sh    <= tx_data;
            last_q   <= tx_last;
            mosi_out <= tx_data[7];
            state    <= SETUP;
          end
        end

        HOLD: begin
          if (tick) begin
            cs_n_out <= 1'b1;
            state    <= GAP;
          end
        end

        GAP: begin
          if (tick) begin
            if (tick_cnt == 8'(CS_GAP - 1)) begin
              state    <= IDLE;
              tx_ready <= 1'b1;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end

        DROP: begin
          if (take && tx_last) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emern_spi_host.sv
// Directed bench for emern_spi_host: miso looped to mosi, rx bytes checked against a scoreboard queue.
module tb_emern_spi_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_sync = 1'b0;
  logic       int_in = 1'b0;
  logic       tx_ready, rx_valid, busy, err, cs_n_out, sck_out, mosi_out, miso;
  logic [7:0] rx_data;

  assign miso = mosi_out;

  always #5 clk = ~clk;

  emern_spi_host #(.CLK_DIV(2), .CS_GAP(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_sync(tx_sync),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .err(err),
    .cs_n_out(cs_n_out), .sck_out(sck_out), .mosi_out(mosi_out),
    .miso_in(miso), .int_in(int_in)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  int cyc = 0, rx_cnt = 0, hs_cnt = 0, sck_rises = 0, cs_low_cyc = 0;
  int cs_rises = 0, cs_falls = 0, cs_high_run = 0, gap_at_ready = 0, err_cnt = 0, err_cyc = 0;
  logic [31:0] mosi_log = '0;
  logic sck_prev = 1'b0, cs_prev = 1'b1, ready_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rx_cnt = 0; hs_cnt = 0; sck_rises = 0; cs_low_cyc = 0;
    cs_rises = 0; cs_falls = 0; err_cnt = 0; mosi_log = '0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst && rx_valid) begin
      rx_cnt++;
      check("rx_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
    if (tx_ready && tx_valid) hs_cnt++;
    if (sck_out && !sck_prev) begin
      sck_rises++;
      mosi_log = {mosi_log[30:0], mosi_out};
    end
    if (!cs_n_out) cs_low_cyc++;
    if (cs_n_out && !cs_prev) cs_rises++;
    if (!cs_n_out && cs_prev) cs_falls++;
    cs_high_run = cs_n_out ? cs_high_run + 1 : 0;
    if (tx_ready && !ready_prev) gap_at_ready = cs_high_run;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    sck_prev   = sck_out;
    cs_prev    = cs_n_out;
    ready_prev = tx_ready;
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input logic sync, input bit expect_rx);
    int n = 0;
    tx_data  = d;
    tx_last  = last;
    tx_sync  = sync;
    tx_valid = 1'b1;
    if (expect_rx) exp_q.push_back(d);
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready && n < 3000);
    check("tx_accepted", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || !tx_ready) && n < 3000);
    check("idle_reached", {31'd0, (!busy && tx_ready)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rx_arrived", 32'(rx_cnt >= target), 32'd1);
  endtask

  initial begin
    int n, s_hi, c_hi, rx_snap, t0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", {31'd0, cs_n_out}, 32'd1);
    check("rst_sck", {31'd0, sck_out}, 32'd0);
    check("rst_mosi", {31'd0, mosi_out}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single byte 0xA5
    clear_stats();
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    check("t1_cs_low_cycles", 32'(cs_low_cyc), 32'd36);
    check("t1_sck_pulses", 32'(sck_rises), 32'd8);
    check("t1_mosi_bits", {24'd0, mosi_log[7:0]}, 32'h0000_00A5);
    check("t1_rx_count", 32'(rx_cnt), 32'd1);
    check("t1_gap_ge4", 32'(gap_at_ready >= 4), 32'd1);

    // Back-to-back 3-byte frame
    clear_stats();
    send_byte(8'h01, 1'b0, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b0, 1'b1);
    send_byte(8'h33, 1'b1, 1'b0, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    check("t2_sck_pulses", 32'(sck_rises), 32'd24);
    check("t2_mosi_bits", {8'd0, mosi_log[23:0]}, 32'h0001_2233);
    check("t2_handshakes", 32'(hs_cnt), 32'd3);
    check("t2_rx_count", 32'(rx_cnt), 32'd3);
    check("t2_cs_rises", 32'(cs_rises), 32'd1);
    check("t2_cs_falls", 32'(cs_falls), 32'd1);

    // Stall between bytes
    clear_stats();
    send_byte(8'h3C, 1'b0, 1'b0, 1'b1);
    tx_valid = 1'b0;
    wait_rx(1);
    s_hi = 0;
    c_hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sck_out) s_hi++;
      if (cs_n_out) c_hi++;
    end
    check("t3_stall_sck_high", 32'(s_hi), 32'd0);
    check("t3_stall_cs_high", 32'(c_hi), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'hC3, 1'b1, 1'b0, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    check("t3_rx_count", 32'(rx_cnt), 32'd2);
    check("t3_mosi_bits", {16'd0, mosi_log[15:0]}, 32'h0000_3CC3);

    // Hold frame until INT
    clear_stats();
    int_in = 1'b0;
    send_byte(8'h96, 1'b1, 1'b1, 1'b1);
    tx_valid = 1'b0;
    tx_sync  = 1'b0;
    c_hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!cs_n_out) c_hi++;
    end
    check("t4_cs_held_high", 32'(c_hi), 32'd0);
    @(posedge clk);
    #1 int_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cs_n_out && n < 20);
    check("t4_int_latency", 32'(n >= 3 && n <= 4), 32'd1);
    wait_idle();
    int_in = 1'b0;
    check("t4_rx_count", 32'(rx_cnt), 32'd1);

    // Reset during bit 4
    clear_stats();
    send_byte(8'hF0, 1'b1, 1'b0, 1'b0);
    tx_valid = 1'b0;
    n = 0;
    while (sck_rises < 5 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    rx_snap = rx_cnt;
    @(posedge clk);
    @(negedge clk);
    check("t5_cs_n", {31'd0, cs_n_out}, 32'd1);
    check("t5_sck", {31'd0, sck_out}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t5_no_rx", 32'(rx_cnt), 32'(rx_snap));
    clear_stats();
    send_byte(8'h5A, 1'b1, 1'b0, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    check("t5_rx_count", 32'(rx_cnt), 32'd1);
    check("t5_mosi_bits", {24'd0, mosi_log[7:0]}, 32'h0000_005A);

`ifdef SPI_HOST_TIMEOUT_EN
    // INT never arrives: frame aborted
    clear_stats();
    int_in = 1'b0;
    send_byte(8'h11, 1'b0, 1'b1, 1'b0);
    t0 = cyc;
    send_byte(8'h22, 1'b1, 1'b0, 1'b0);
    tx_valid = 1'b0;
    tx_sync  = 1'b0;
    wait_idle();
    check("t6_err_pulses", 32'(err_cnt), 32'd1);
    check("t6_err_time", 32'((err_cyc - t0) >= 95 && (err_cyc - t0) <= 110), 32'd1);
    check("t6_cs_falls", 32'(cs_falls), 32'd0);
    check("t6_handshakes", 32'(hs_cnt), 32'd2);
    check("t6_rx_count", 32'(rx_cnt), 32'd0);
`else
    t0 = 0;
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
